reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 issue_valid  input  1  issue request; accepted on a rising edge when issue_ready=1.
REQ-004 issue_ready  output  1  at least one of 4 entries free.
REQ-005 issue_instruction  input  16  instruction word; opcode in bits [3:0] (0000 ADD, 0001 SUB, 0100 MUL, 0101 DIV).
REQ-006 issue_tag  input  3  result tag of issued instruction.
REQ-007 issue_vj, issue_vk  input  16 each  operand values, valid when the matching q*_valid=0.
REQ-008 issue_qj_valid, issue_qk_valid  input  1 each  operand pending on a producer.
REQ-009 issue_qj, issue_qk  input  3 each  producer tags for pending operands.
REQ-010 cdb_valid  input  1  common data bus broadcast valid.
REQ-011 cdb_tag, cdb_value  input  3, 16  broadcast tag and result.
REQ-012 instructIn  output  1  one-cycle dispatch strobe to the functional unit.
REQ-013 instruction  output  16  dispatched instruction word.
REQ-014 instructionCodeIn  output  3  dispatched tag.
REQ-015 R1, R2  output  16 each  R1 = Vk, R2 = Vj (FU computes R2 op R1).
REQ-016 disponivelUF  input  1  functional unit available.
REQ-017 done  input  1  functional unit completion pulse.
REQ-018 busy_count  output  3  number of occupied entries (0..4).

Function
REQ-019 Four entries, each: busy, instr[15:0], tag[2:0], vj, vk, qj_valid, qj, qk_valid, qk, age[1:0].
REQ-020 Issue: issue_valid & issue_ready writes the lowest-index free entry; age = busy_count before the write (oldest = 0).
REQ-021 Issue with issue_valid=1 and issue_ready=0 is ignored; no state change.
REQ-022 CDB capture: each cycle with cdb_valid=1, every busy entry with qj_valid & qj==cdb_tag loads vj=cdb_value and clears qj_valid; likewise for k.
REQ-023 Same-cycle forwarding: an issuing entry whose issue_qj/qk equals cdb_tag while cdb_valid=1 stores cdb_value and is written with q*_valid=0.
REQ-024 An entry is ready when busy & !qj_valid & !qk_valid.
REQ-025 Internal fu_busy flag: set on dispatch, cleared when done=1.
REQ-026 Dispatch condition: !fu_busy & disponivelUF & at least one ready entry; the ready entry with lowest age is selected.
REQ-027 On dispatch: registered instructIn=1 for exactly one cycle with instruction, instructionCodeIn, R1, R2 from the selected entry; the entry is freed in the same edge; ages of younger entries decrement by 1.
REQ-028 instruction/instructionCodeIn/R1/R2 hold their last dispatched values while instructIn=0.
REQ-029 An operand captured from the CDB in cycle N makes its entry eligible for dispatch at the edge after N; no same-edge capture-and-dispatch.
REQ-030 Simultaneous issue and dispatch: both take effect; the free slot from dispatch is not reused that edge; new entry age = busy_count - 1.
REQ-031 done and dispatch on the same edge: fu_busy clears; dispatch waits one cycle.
REQ-032 busy_count and issue_ready reflect registered state; issue_ready = (busy_count < 4).
REQ-033 Opcodes other than the four listed are held and dispatched unchanged.

Reset
REQ-034 resetn=0 asynchronously clears all busy, qj_valid, qk_valid, ages and fu_busy; instructIn=0, instruction=0, instructionCodeIn=0, R1=R2=0, busy_count=0, issue_ready=1.
REQ-035 Reset mid-operation discards all entries; done pulses after reset release are ignored while fu_busy=0.

Verification
REQ-036 Issue ADD tag 1, vj=5, vk=3, both ready, disponivelUF=1 -> next edge instructIn=1, R2=5, R1=3, instructionCodeIn=1; busy_count returns to 0.
REQ-037 Issue SUB tag 2 with qj=4 pending; cdb_valid, tag 4, value 0x0010 two cycles later -> dispatch one cycle after capture with R2=0x0010.
REQ-038 Issue 4 entries with pending operands -> issue_ready=0; a fifth issue is ignored; busy_count=4.
REQ-039 Two ready entries (ages 0,1), FU busy until done -> after done, the age-0 entry dispatches first; the second dispatches only after a further done.
REQ-040 Issue with issue_qk=3 while cdb_valid, cdb_tag=3, cdb_value=7 -> entry stored with vk=7, qk_valid=0.
REQ-041 resetn low during pending dispatch with 3 entries -> all outputs at reset values, busy_count=0, no instructIn after release.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - four-entry reservation station with CDB capture and age-ordered dispatch
module reservation_station (
  input  logic        clock,
  input  logic        resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [15:0] issue_instruction,
  input  logic [2:0]  issue_tag,
  input  logic [15:0] issue_vj,
  input  logic [15:0] issue_vk,
  input  logic        issue_qj_valid,
  input  logic        issue_qk_valid,
  input  logic [2:0]  issue_qj,
  input  logic [2:0]  issue_qk,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [15:0] cdb_value,
  output logic        instructIn,
  output logic [15:0] instruction,
  output logic [2:0]  instructionCodeIn,
  output logic [15:0] R1,
  output logic [15:0] R2,
  input  logic        disponivelUF,
  input  logic        done,
  output logic [2:0]  busy_count
);

  logic [3:0]  r_busy;
  logic [3:0]  r_qjv;
  logic [3:0]  r_qkv;
  logic [15:0] r_instr [4];
  logic [2:0]  r_tag   [4];
  logic [15:0] r_vj    [4];
  logic [15:0] r_vk    [4];
  logic [2:0]  r_qj    [4];
  logic [2:0]  r_qk    [4];
  logic [1:0]  r_age   [4];
  logic        r_fu_busy;

  logic [3:0]  w_ready;
  logic [2:0]  w_count;
  logic        w_issue;
  logic        w_disp;
  logic        w_any_ready;
  logic        w_free_found;
  logic [1:0]  w_free_idx;
  logic [1:0]  w_sel_idx;
  logic [1:0]  w_sel_age;
  logic [1:0]  w_new_age;
  logic        w_fwd_j;
  logic        w_fwd_k;

  // Occupancy, readiness and lowest-index free slot, all from registered state
  always_comb begin
    w_count      = 3'd0;
    w_free_found = 1'b0;
    w_free_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_count    = w_count + {2'b00, r_busy[i]};
      w_ready[i] = r_busy[i] & ~r_qjv[i] & ~r_qkv[i];
      if (!r_busy[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = 2'(i);
      end
    end
  end

  // Pick the oldest ready entry (smallest age)
  always_comb begin
    w_any_ready = 1'b0;
    w_sel_idx   = 2'd0;
    w_sel_age   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_ready[i] && (!w_any_ready || r_age[i] < w_sel_age)) begin
        w_any_ready = 1'b1;
        w_sel_idx   = 2'(i);
        w_sel_age   = r_age[i];
      end
    end
  end

  assign busy_count  = w_count;
  assign issue_ready = (w_count < 3'd4);
  assign w_issue     = issue_valid & issue_ready;
  assign w_disp      = ~r_fu_busy & disponivelUF & w_any_ready;
  // A dispatch on the same edge removes one older entry, so the newcomer lands one age lower
  assign w_new_age   = w_count[1:0] - {1'b0, w_disp};
  assign w_fwd_j     = cdb_valid & (issue_qj == cdb_tag);
  assign w_fwd_k     = cdb_valid & (issue_qk == cdb_tag);

  // Entry storage: CDB capture, age compaction on dispatch, free on dispatch, write on issue
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 4'd0;
      r_qjv  <= 4'd0;
      r_qkv  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_instr[i] <= 16'd0;
        r_tag[i]   <= 3'd0;
        r_vj[i]    <= 16'd0;
        r_vk[i]    <= 16'd0;
        r_qj[i]    <= 3'd0;
        r_qk[i]    <= 3'd0;
        r_age[i]   <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_busy[i]) begin
          if (cdb_valid && r_qjv[i] && r_qj[i] == cdb_tag) begin
            r_vj[i]  <= cdb_value;
            r_qjv[i] <= 1'b0;
          end
          if (cdb_valid && r_qkv[i] && r_qk[i] == cdb_tag) begin
            r_vk[i]  <= cdb_value;
            r_qkv[i] <= 1'b0;
          end
          if (w_disp && r_age[i] > w_sel_age) begin
            r_age[i] <= r_age[i] - 2'd1;
          end
        end
      end
      if (w_disp) begin
        r_busy[w_sel_idx] <= 1'b0;
      end
      if (w_issue) begin
        r_busy[w_free_idx]  <= 1'b1;
        r_instr[w_free_idx] <= issue_instruction;
        r_tag[w_free_idx]   <= issue_tag;
        r_qj[w_free_idx]    <= issue_qj;
        r_qk[w_free_idx]    <= issue_qk;
        r_age[w_free_idx]   <= w_new_age;
        r_vj[w_free_idx]    <= (issue_qj_valid && w_fwd_j) ? cdb_value : issue_vj;
        r_vk[w_free_idx]    <= (issue_qk_valid && w_fwd_k) ? cdb_value : issue_vk;
        r_qjv[w_free_idx]   <= issue_qj_valid & ~w_fwd_j;
        r_qkv[w_free_idx]   <= issue_qk_valid & ~w_fwd_k;
      end
    end
  end

  // Functional-unit occupancy: set by a dispatch, cleared by the completion pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fu_busy <= 1'b0;
    end else if (w_disp) begin
      r_fu_busy <= 1'b1;
    end else if (done) begin
      r_fu_busy <= 1'b0;
    end
  end

  // Registered dispatch outputs; payload holds its last value between strobes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      instructIn        <= 1'b0;
      instruction       <= 16'd0;
      instructionCodeIn <= 3'd0;
      R1                <= 16'd0;
      R2                <= 16'd0;
    end else begin
      instructIn <= w_disp;
      if (w_disp) begin
        instruction       <= r_instr[w_sel_idx];
        instructionCodeIn <= r_tag[w_sel_idx];
        R1                <= r_vk[w_sel_idx];
        R2                <= r_vj[w_sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;

  logic        clock = 1'b0;
  logic        resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] issue_instruction;
  logic [2:0]  issue_tag;
  logic [15:0] issue_vj, issue_vk;
  logic        issue_qj_valid, issue_qk_valid;
  logic [2:0]  issue_qj, issue_qk;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic        instructIn;
  logic [15:0] instruction;
  logic [2:0]  instructionCodeIn;
  logic [15:0] R1, R2;
  logic        disponivelUF;
  logic        done;
  logic [2:0]  busy_count;

  typedef struct packed {
    logic [15:0] instr;
    logic [2:0]  tag;
    logic [15:0] r1;
    logic [15:0] r2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  reservation_station dut (
    .clock(clock), .resetn(resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instruction(issue_instruction), .issue_tag(issue_tag),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .instructIn(instructIn), .instruction(instruction),
    .instructionCodeIn(instructionCodeIn), .R1(R1), .R2(R2),
    .disponivelUF(disponivelUF), .done(done), .busy_count(busy_count)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Monitor: every dispatch strobe is popped against the scoreboard
  always @(negedge clock) begin
    if (resetn && instructIn) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dispatch_unexpected: got instr=%h tag=%0d R1=%h R2=%h, none expected",
                 instruction, instructionCodeIn, R1, R2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instruction !== e.instr || instructionCodeIn !== e.tag || R1 !== e.r1 || R2 !== e.r2) begin
          fails++;
          $display("FAIL dispatch_payload: got instr=%h tag=%0d R1=%h R2=%h, want instr=%h tag=%0d R1=%h R2=%h",
                   instruction, instructionCodeIn, R1, R2, e.instr, e.tag, e.r1, e.r2);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_disp(input logic [15:0] instr, input logic [2:0] tag,
                             input logic [15:0] r1, input logic [15:0] r2);
    exp_t e;
    e.instr = instr; e.tag = tag; e.r1 = r1; e.r2 = r2;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] instr, input logic [2:0] tag,
                       input logic [15:0] vj, input logic [15:0] vk,
                       input logic qjv, input logic [2:0] qj,
                       input logic qkv, input logic [2:0] qk);
    issue_valid       = 1'b1;
    issue_instruction = instr;
    issue_tag         = tag;
    issue_vj          = vj;
    issue_vk          = vk;
    issue_qj_valid    = qjv;
    issue_qj          = qj;
    issue_qk_valid    = qkv;
    issue_qk          = qk;
    tick();
    issue_valid       = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_disp(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (instructIn) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    resetn = 1'b0; issue_valid = 1'b0; issue_instruction = '0; issue_tag = '0;
    issue_vj = '0; issue_vk = '0; issue_qj_valid = 1'b0; issue_qk_valid = 1'b0;
    issue_qj = '0; issue_qk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    disponivelUF = 1'b1; done = 1'b0;
    #12;
    check("rst_instructIn", {31'd0, instructIn}, 0);
    check("rst_busy_count", {29'd0, busy_count}, 0);
    check("rst_issue_ready", {31'd0, issue_ready}, 1);
    check("rst_payload", {instruction, R1 ^ R2}, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Ready ADD dispatches on the edge after issue
    expect_disp(16'h0000, 3'd1, 16'd3, 16'd5);
    issue(16'h0000, 3'd1, 16'd5, 16'd3, 1'b0, 3'd0, 1'b0, 3'd0);
    check("add_busy_after_issue", {29'd0, busy_count}, 1);
    tick();
    check("add_dispatch", {31'd0, instructIn}, 1);
    check("add_busy_after_disp", {29'd0, busy_count}, 0);
    pulse_done();

    // SUB waiting on tag 4, captured from the CDB two cycles later
    expect_disp(16'h0001, 3'd2, 16'd2, 16'h0010);
    issue(16'h0001, 3'd2, 16'h0000, 16'd2, 1'b1, 3'd4, 1'b0, 3'd0);
    tick();
    tick();
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 16'h0010;
    tick();
    cdb_valid = 1'b0;
    check("sub_no_same_edge_disp", {31'd0, instructIn}, 0);
    tick();
    check("sub_disp_after_capture", {31'd0, instructIn}, 1);
    pulse_done();

    // Same-cycle forwarding into an issuing entry
    disponivelUF = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_value = 16'd7;
    issue(16'h0004, 3'd5, 16'd9, 16'd0, 1'b0, 3'd0, 1'b1, 3'd3);
    cdb_valid = 1'b0;
    expect_disp(16'h0004, 3'd5, 16'd7, 16'd9);
    disponivelUF = 1'b1;
    tick();
    check("fwd_disp", {31'd0, instructIn}, 1);
    pulse_done();

    // Fill all four entries, fifth issue ignored, then release in age order
    disponivelUF = 1'b0;
    for (int j = 0; j < 4; j++) begin
      issue(16'h0100 + 16'(j), 3'(j), 16'd0, 16'h0010 * 16'(j) + 16'd1, 1'b1, 3'd6, 1'b0, 3'd0);
      check("fill_busy_count", {29'd0, busy_count}, j + 1);
    end
    check("full_issue_ready", {31'd0, issue_ready}, 0);
    issue(16'h0FFF, 3'd7, 16'd1, 16'd1, 1'b0, 3'd0, 1'b0, 3'd0);
    check("full_fifth_ignored", {29'd0, busy_count}, 4);
    for (int j = 0; j < 4; j++)
      expect_disp(16'h0100 + 16'(j), 3'(j), 16'h0010 * 16'(j) + 16'd1, 16'h0A0A);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_value = 16'h0A0A;
    disponivelUF = 1'b1;
    tick();
    cdb_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_disp("full_drain_disp");
      pulse_done();
    end
    check("drain_busy_count", {29'd0, busy_count}, 0);

    // Two ready entries behind a busy FU; oldest goes first, one per done
    expect_disp(16'h0000, 3'd1, 16'd1, 16'd1);
    expect_disp(16'h0001, 3'd2, 16'h2222, 16'h1111);
    expect_disp(16'hBEEF, 3'd3, 16'h4444, 16'h3333);
    issue(16'h0000, 3'd1, 16'd1, 16'd1, 1'b0, 3'd0, 1'b0, 3'd0);
    issue(16'h0001, 3'd2, 16'h1111, 16'h2222, 1'b0, 3'd0, 1'b0, 3'd0);
    check("simul_issue_disp", {31'd0, instructIn}, 1);
    issue(16'hBEEF, 3'd3, 16'h3333, 16'h4444, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    tick();
    check("fu_busy_hold", {31'd0, instructIn}, 0);
    check("fu_busy_count", {29'd0, busy_count}, 2);
    pulse_done();
    check("done_edge_no_disp", {31'd0, instructIn}, 0);
    tick();
    check("age0_disp", {31'd0, instructIn}, 1);
    tick();
    tick();
    check("second_waits", {31'd0, instructIn}, 0);
    check("second_busy_count", {29'd0, busy_count}, 1);
    pulse_done();
    tick();
    check("second_disp", {31'd0, instructIn}, 1);

    // Reset with three entries queued behind a busy FU
    for (int j = 0; j < 3; j++)
      issue(16'h0005, 3'(j), 16'd8, 16'd8, 1'b0, 3'd0, 1'b0, 3'd0);
    check("pre_reset_count", {29'd0, busy_count}, 3);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_outputs", {instruction, 13'd0, instructionCodeIn}, 0);
    check("mid_rst_R", {R1, R2}, 0);
    check("mid_rst_busy_count", {29'd0, busy_count}, 0);
    check("mid_rst_issue_ready", {31'd0, issue_ready}, 1);
    tick();
    tick();
    resetn = 1'b1;
    pulse_done();
    for (int c = 0; c < 6; c++) tick();
    check("post_rst_busy_count", {29'd0, busy_count}, 0);
    expect_disp(16'h0004, 3'd6, 16'h00CD, 16'h00AB);
    issue(16'h0004, 3'd6, 16'h00AB, 16'h00CD, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    check("post_rst_disp", {31'd0, instructIn}, 1);
    pulse_done();
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
